snitch_axi_mem_responder: RTL and testbench

//  AXI4 subordinate test memory that terminates the cluster's outbound narrow

---
 rtl/snitch_axi_mem_responder_pkg.sv | 88 ++++++++
 rtl/snitch_axi_mem_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_snitch_axi_mem_responder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_axi_mem_responder_pkg.sv
// AXI4 channel and bundle types for the cluster's outbound narrow port
// (48-bit address, 64-bit data, 4-bit IDs), plus burst and response encodings.
package snitch_axi_mem_responder_pkg;

  localparam int unsigned NarrowAddrWidth   = 48;
  localparam int unsigned NarrowDataWidth   = 64;
  localparam int unsigned NarrowIdWidthOut  = 4;
  localparam int unsigned NarrowUserWidth   = 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [NarrowIdWidthOut-1:0]  id;
    logic [NarrowAddrWidth-1:0]   addr;
    logic [7:0]                   len;
    logic [2:0]                   size;
    logic [1:0]                   burst;
    logic                         lock;
    logic [3:0]                   cache;
    logic [2:0]                   prot;
    logic [3:0]                   qos;
    logic [3:0]                   region;
    logic [5:0]                   atop;
    logic [NarrowUserWidth-1:0]   user;
  } narrow_out_aw_chan_t;

  typedef struct packed {
    logic [NarrowDataWidth-1:0]   data;
    logic [NarrowDataWidth/8-1:0] strb;
    logic                         last;
    logic [NarrowUserWidth-1:0]   user;
  } narrow_out_w_chan_t;

  typedef struct packed {
    logic [NarrowIdWidthOut-1:0]  id;
    logic [1:0]                   resp;
    logic [NarrowUserWidth-1:0]   user;
  } narrow_out_b_chan_t;

  typedef struct packed {
    logic [NarrowIdWidthOut-1:0]  id;
    logic [NarrowAddrWidth-1:0]   addr;
    logic [7:0]                   len;
    logic [2:0]                   size;
    logic [1:0]                   burst;
    logic                         lock;
    logic [3:0]                   cache;
    logic [2:0]                   prot;
    logic [3:0]                   qos;
    logic [3:0]                   region;
    logic [NarrowUserWidth-1:0]   user;
  } narrow_out_ar_chan_t;

  typedef struct packed {
    logic [NarrowIdWidthOut-1:0]  id;
    logic [NarrowDataWidth-1:0]   data;
    logic [1:0]                   resp;
    logic                         last;
    logic [NarrowUserWidth-1:0]   user;
  } narrow_out_r_chan_t;

  typedef struct packed {
    narrow_out_aw_chan_t aw;
    logic                aw_valid;
    narrow_out_w_chan_t  w;
    logic                w_valid;
    logic                b_ready;
    narrow_out_ar_chan_t ar;
    logic                ar_valid;
    logic                r_ready;
  } narrow_out_req_t;

  typedef struct packed {
    logic                aw_ready;
    logic                ar_ready;
    logic                w_ready;
    logic                b_valid;
    narrow_out_b_chan_t  b;
    logic                r_valid;
    narrow_out_r_chan_t  r;
  } narrow_out_resp_t;

endpackage

// File: rtl/snitch_axi_mem_responder.sv
// AXI4 subordinate test memory: serves one burst at a time from a word-addressed
// array, echoes IDs, honours write strobes and flags out-of-range, WRAP and ATOP
// traffic with SLVERR. Read data is registered and the next beat is prefetched.
module snitch_axi_mem_responder
  import snitch_axi_mem_responder_pkg::*;
#(
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          IdWidth   = 4,
  parameter int unsigned          MemWords  = 256,
  parameter logic [AddrWidth-1:0] BaseAddr  = 48'h8000_0000,
  parameter type                  axi_req_t = narrow_out_req_t,
  parameter type                  axi_rsp_t = narrow_out_resp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o,
  output logic     busy_o
);

  localparam int unsigned BytesPerBeat = DataWidth / 8;
  localparam int unsigned OffBits      = $clog2(BytesPerBeat);
  localparam int unsigned IdxBits      = $clog2(MemWords);
  localparam logic [AddrWidth:0] BaseExt = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0] EndExt  =
    BaseExt + (AddrWidth+1)'(MemWords * BytesPerBeat);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e state_q, state_d;
  logic   last_was_write_q, last_was_write_d;

  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [7:0]           beat_q;
  logic                 err_q;

  logic                 r_valid_q;
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  logic                 r_last_q;

  logic [DataWidth-1:0] mem [MemWords];

  logic sel_aw, aw_rdy, ar_rdy, w_rdy, b_vld, r_vld;
  logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic [AddrWidth-1:0] next_addr;

  function automatic logic in_range(input logic [AddrWidth-1:0] addr);
    return ({1'b0, addr} >= BaseExt) && ({1'b0, addr} < EndExt);
  endfunction

  function automatic logic [IdxBits-1:0] word_idx(input logic [AddrWidth-1:0] addr);
    logic [AddrWidth-1:0] off;
    off = addr - BaseAddr;
    return off[OffBits +: IdxBits];
  endfunction

  assign next_addr = (burst_q == BURST_FIXED) ? addr_q
                                              : addr_q + (AddrWidth'(1) << size_q);

  // State register and write/read arbitration history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      last_was_write_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_was_write_q <= last_was_write_d;
    end
  end

  // Next-state logic and channel handshake signals; everything is silenced in reset.
  always_comb begin
    state_d          = state_q;
    last_was_write_d = last_was_write_q;
    sel_aw           = 1'b0;
    aw_rdy           = 1'b0;
    ar_rdy           = 1'b0;
    w_rdy            = 1'b0;
    b_vld            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (axi_req_i.aw_valid) begin
          sel_aw = !axi_req_i.ar_valid || !last_was_write_q;
        end else begin
          sel_aw = !axi_req_i.ar_valid && !last_was_write_q;
        end
        aw_rdy = sel_aw;
        ar_rdy = !sel_aw;
        if (axi_req_i.aw_valid && sel_aw) begin
          state_d = WDATA;
        end else if (axi_req_i.ar_valid && !sel_aw) begin
          state_d = RDATA;
        end
      end
      WDATA: begin
        w_rdy = 1'b1;
        if (axi_req_i.w_valid && axi_req_i.w.last) state_d = WRESP;
      end
      WRESP: begin
        b_vld = 1'b1;
        if (axi_req_i.b_ready) begin
          state_d          = IDLE;
          last_was_write_d = 1'b1;
        end
      end
      RDATA: begin
        if (r_valid_q && axi_req_i.r_ready && r_last_q) begin
          state_d          = IDLE;
          last_was_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      aw_rdy = 1'b0;
      ar_rdy = 1'b0;
      w_rdy  = 1'b0;
      b_vld  = 1'b0;
    end
  end

  assign r_vld = r_valid_q && !rst_i;
  assign aw_hs = aw_rdy && axi_req_i.aw_valid;
  assign ar_hs = ar_rdy && axi_req_i.ar_valid;
  assign w_hs  = w_rdy  && axi_req_i.w_valid;
  assign b_hs  = b_vld  && axi_req_i.b_ready;
  assign r_hs  = r_vld  && axi_req_i.r_ready;

  // Burst bookkeeping, error tracking and the registered/prefetched read beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
    end else if (aw_hs) begin
      id_q    <= axi_req_i.aw.id;
      addr_q  <= axi_req_i.aw.addr;
      len_q   <= axi_req_i.aw.len;
      size_q  <= axi_req_i.aw.size;
      burst_q <= axi_req_i.aw.burst;
      beat_q  <= '0;
      err_q   <= (axi_req_i.aw.atop != 6'd0) || (axi_req_i.aw.burst == BURST_WRAP);
    end else if (ar_hs) begin
      id_q      <= axi_req_i.ar.id;
      addr_q    <= axi_req_i.ar.addr;
      len_q     <= axi_req_i.ar.len;
      size_q    <= axi_req_i.ar.size;
      burst_q   <= axi_req_i.ar.burst;
      beat_q    <= '0;
      err_q     <= (axi_req_i.ar.burst == BURST_WRAP);
      r_valid_q <= 1'b1;
      r_data_q  <= in_range(axi_req_i.ar.addr) ? mem[word_idx(axi_req_i.ar.addr)] : '0;
      r_resp_q  <= in_range(axi_req_i.ar.addr) ? RESP_OKAY : RESP_SLVERR;
      r_last_q  <= (axi_req_i.ar.len == 8'd0);
    end else if (w_hs) begin
      addr_q <= next_addr;
      beat_q <= beat_q + 8'd1;
      if (!in_range(addr_q) || ((beat_q == len_q) && !axi_req_i.w.last)) begin
        err_q <= 1'b1;
      end
    end else if (r_hs) begin
      if (r_last_q) begin
        r_valid_q <= 1'b0;
      end else begin
        addr_q   <= next_addr;
        beat_q   <= beat_q + 8'd1;
        r_data_q <= in_range(next_addr) ? mem[word_idx(next_addr)] : '0;
        r_resp_q <= in_range(next_addr) ? RESP_OKAY : RESP_SLVERR;
        r_last_q <= ((beat_q + 8'd1) == len_q);
      end
    end
  end

  // Strobed byte writes into the array; out-of-range beats are dropped.
  always_ff @(posedge clk_i) begin
    if (w_hs && in_range(addr_q)) begin
      for (int i = 0; i < BytesPerBeat; i++) begin
        if (axi_req_i.w.strb[i]) begin
          mem[word_idx(addr_q)][8*i +: 8] <= axi_req_i.w.data[8*i +: 8];
        end
      end
    end
  end

  // Response bundle assembly; all fields read as zero while in reset.
  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_rdy;
    axi_rsp_o.ar_ready = ar_rdy;
    axi_rsp_o.w_ready  = w_rdy;
    axi_rsp_o.b_valid  = b_vld;
    axi_rsp_o.r_valid  = r_vld;
    if (!rst_i) begin
      axi_rsp_o.b.id   = id_q;
      axi_rsp_o.b.resp = err_q ? RESP_SLVERR : RESP_OKAY;
      axi_rsp_o.r.id   = id_q;
      axi_rsp_o.r.data = r_data_q;
      axi_rsp_o.r.resp = r_resp_q;
      axi_rsp_o.r.last = r_last_q;
    end
  end

  assign busy_o = (state_q != IDLE) && !rst_i;

  logic unused_req_fields;
  assign unused_req_fields = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                               axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user,
                               axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                               axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.ar.user,
                               axi_req_i.w.user, b_hs};

  // Atomic operations with atop[5] set have no defined meaning here.
  atop_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                 aw_hs |-> !axi_req_i.aw.atop[5]);

endmodule

// File: tb/tb_snitch_axi_mem_responder.sv
// Scoreboard bench for snitch_axi_mem_responder: stimulus pushes expected B/R
// responses into queues, a negedge monitor pops and compares on each handshake.
module tb_snitch_axi_mem_responder;
  import snitch_axi_mem_responder_pkg::*;

  localparam logic [47:0] Base = 48'h8000_0000;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } exp_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_r_t;

  logic             clk = 1'b0;
  logic             rst;
  narrow_out_req_t  req;
  narrow_out_resp_t rsp;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int r_seen       = 0;

  exp_b_t exp_b [$];
  exp_r_t exp_r [$];

  logic [63:0] beat_data [8];
  logic [7:0]  beat_strb [8];
  logic [1:0]  snap;
  int          r_before;
  bit          t5_done;

  always #5 clk = ~clk;

  snitch_axi_mem_responder dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .axi_req_i (req),
    .axi_rsp_o (rsp),
    .busy_o    (busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [5:0] atop);
    req.aw       = '0;
    req.aw.id    = id;
    req.aw.addr  = addr;
    req.aw.len   = len;
    req.aw.size  = 3'd3;
    req.aw.burst = burst;
    req.aw.atop  = atop;
    req.aw_valid = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    req.ar       = '0;
    req.ar.id    = id;
    req.ar.addr  = addr;
    req.ar.len   = len;
    req.ar.size  = 3'd3;
    req.ar.burst = burst;
    req.ar_valid = 1'b1;
  endtask

  // Waits (bounded) for the ready of channel ch (0=AW, 1=W, 2=AR), returning the
  // {aw_ready, ar_ready} pair seen in the cycle of the handshake.
  task automatic wait_chan(input int ch, output logic [1:0] rdy_snap);
    int cyc = 0;
    bit seen = 0;
    rdy_snap = '0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (ch)
        0:       seen = rsp.aw_ready;
        1:       seen = rsp.w_ready;
        default: seen = rsp.ar_ready;
      endcase
      rdy_snap = {rsp.aw_ready, rsp.ar_ready};
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL handshake_timeout: channel %0d never ready", ch);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    logic [1:0] s;
    req.w       = '0;
    req.w.data  = data;
    req.w.strb  = strb;
    req.w.last  = last;
    req.w_valid = 1'b1;
    wait_chan(1, s);
    req.w_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((exp_b.size() != 0 || exp_r.size() != 0 || busy) && cyc < 1000);
    if (exp_b.size() != 0 || exp_r.size() != 0 || busy) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain_timeout: %0d B and %0d R responses outstanding",
               exp_b.size(), exp_r.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst          = 1'b1;
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    req.w_valid  = 1'b0;
    @(negedge clk);
    checkOutput("reset_rsp_zero", rsp, '0);
    checkOutput("reset_busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One full burst with size=3; data/strobes come from beat_data/beat_strb.
  task automatic applyStimulus(input bit is_write, input logic [3:0] id, input logic [47:0] addr,
                               input logic [7:0] len, input logic [1:0] burst,
                               input logic [5:0] atop, input logic [1:0] exp_resp);
    logic [1:0] s;
    if (is_write) begin
      exp_b.push_back('{id: id, resp: exp_resp});
      set_aw(id, addr, len, burst, atop);
      wait_chan(0, s);
      req.aw_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
        send_w(beat_data[i], beat_strb[i], i == int'(len));
      end
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        exp_r.push_back('{id: id, data: beat_data[i], resp: exp_resp, last: (i == int'(len))});
      end
      set_ar(id, addr, len, burst);
      wait_chan(2, s);
      req.ar_valid = 1'b0;
    end
    drain();
  endtask

  // Monitor: pops expectations on every B/R handshake and checks R stability under stall.
  initial begin
    exp_b_t             eb;
    exp_r_t             er;
    logic               stall_prev;
    narrow_out_r_chan_t stall_r;
    stall_prev = 1'b0;
    stall_r    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checkOutput("r_valid_held", rsp.r_valid, 1'b1);
          checkOutput("r_stable", rsp.r, stall_r);
        end
        if (rsp.b_valid && req.b_ready) begin
          if (exp_b.size() == 0) begin
            checkOutput("unexpected_b", rsp.b_valid, 1'b0);
          end else begin
            eb = exp_b.pop_front();
            checkOutput("b_id", rsp.b.id, eb.id);
            checkOutput("b_resp", rsp.b.resp, eb.resp);
          end
        end
        if (rsp.r_valid && req.r_ready) begin
          r_seen++;
          if (exp_r.size() == 0) begin
            checkOutput("unexpected_r", rsp.r_valid, 1'b0);
          end else begin
            er = exp_r.pop_front();
            checkOutput("r_id", rsp.r.id, er.id);
            checkOutput("r_data", rsp.r.data, er.data);
            checkOutput("r_resp", rsp.r.resp, er.resp);
            checkOutput("r_last", rsp.r.last, er.last);
          end
        end
        stall_prev = rsp.r_valid && !req.r_ready;
        stall_r    = rsp.r;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    req         = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    t5_done     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat_data[i] = '0;
      beat_strb[i] = 8'hFF;
    end
    @(negedge clk);
    checkOutput("reset_rsp_zero", rsp, '0);
    checkOutput("reset_busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_w_ready", rsp.w_ready, 1'b0);
    checkOutput("idle_b_valid", rsp.b_valid, 1'b0);
    checkOutput("idle_r_valid", rsp.r_valid, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] test 1: INCR burst write and readback");
    for (int i = 0; i < 4; i++) beat_data[i] = 64'(i + 1);
    applyStimulus(1'b1, 4'd5, Base + 48'h10, 8'd3, BURST_INCR, 6'd0, RESP_OKAY);
    applyStimulus(1'b0, 4'd5, Base + 48'h10, 8'd3, BURST_INCR, 6'd0, RESP_OKAY);

    $display("[TB] test 2: partial strobes");
    beat_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(1'b1, 4'd2, Base + 48'h100, 8'd0, BURST_INCR, 6'd0, RESP_OKAY);
    beat_data[0] = 64'h0;
    beat_strb[0] = 8'h0F;
    applyStimulus(1'b1, 4'd2, Base + 48'h100, 8'd0, BURST_INCR, 6'd0, RESP_OKAY);
    beat_strb[0] = 8'hFF;
    beat_data[0] = 64'hFFFF_FFFF_0000_0000;
    applyStimulus(1'b0, 4'd2, Base + 48'h100, 8'd0, BURST_INCR, 6'd0, RESP_OKAY);

    $display("[TB] test 3: out-of-range and ATOP errors");
    beat_data[0] = 64'hDEAD_BEEF;
    applyStimulus(1'b1, 4'd7, Base - 48'h8, 8'd0, BURST_INCR, 6'd0, RESP_SLVERR);
    beat_data[0] = 64'h0;
    applyStimulus(1'b0, 4'd9, Base + 48'h800, 8'd0, BURST_INCR, 6'd0, RESP_SLVERR);
    beat_data[0] = 64'h1234;
    applyStimulus(1'b1, 4'd4, Base + 48'h500, 8'd0, BURST_INCR, 6'h01, RESP_SLVERR);

    $display("[TB] test 4: AW/AR arbitration");
    pulse_reset();
    exp_b.push_back('{id: 4'd1, resp: RESP_OKAY});
    exp_r.push_back('{id: 4'd2, data: 64'd1, resp: RESP_OKAY, last: 1'b1});
    exp_b.push_back('{id: 4'd3, resp: RESP_OKAY});
    set_aw(4'd1, Base + 48'h200, 8'd0, BURST_INCR, 6'd0);
    set_ar(4'd2, Base + 48'h10, 8'd0, BURST_INCR);
    wait_chan(0, snap);
    checkOutput("t4_first_grant_aw", snap, 2'b10);
    req.aw_valid = 1'b0;
    checkOutput("t4_busy_in_burst", busy, 1'b1);
    send_w(64'hA1, 8'hFF, 1'b1);
    set_aw(4'd3, Base + 48'h208, 8'd0, BURST_INCR, 6'd0);
    wait_chan(2, snap);
    checkOutput("t4_second_grant_ar", snap, 2'b01);
    req.ar_valid = 1'b0;
    wait_chan(0, snap);
    req.aw_valid = 1'b0;
    send_w(64'hB2, 8'hFF, 1'b1);
    drain();

    $display("[TB] test 5: read with r_ready toggling");
    for (int i = 0; i < 8; i++) beat_data[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    applyStimulus(1'b1, 4'd6, Base + 48'h300, 8'd7, BURST_INCR, 6'd0, RESP_OKAY);
    r_before = r_seen;
    fork
      begin
        applyStimulus(1'b0, 4'd6, Base + 48'h300, 8'd7, BURST_INCR, 6'd0, RESP_OKAY);
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge clk);
          #1;
          req.r_ready = !req.r_ready;
        end
        req.r_ready = 1'b1;
      end
    join
    checkOutput("t5_beat_count", 32'(r_seen - r_before), 32'd8);

    $display("[TB] test 6: reset in the middle of a write burst");
    for (int i = 0; i < 4; i++) beat_data[i] = 64'hA0 + 64'(i);
    applyStimulus(1'b1, 4'd8, Base + 48'h400, 8'd3, BURST_INCR, 6'd0, RESP_OKAY);
    set_aw(4'd8, Base + 48'h400, 8'd3, BURST_INCR, 6'd0);
    wait_chan(0, snap);
    req.aw_valid = 1'b0;
    send_w(64'hE0, 8'hFF, 1'b0);
    send_w(64'hE1, 8'hFF, 1'b0);
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t6_no_b", rsp.b_valid, 1'b0);
      checkOutput("t6_not_busy", busy, 1'b0);
    end
    @(posedge clk);
    #1;
    beat_data[0] = 64'hE0;
    beat_data[1] = 64'hE1;
    beat_data[2] = 64'hA2;
    beat_data[3] = 64'hA3;
    applyStimulus(1'b0, 4'd8, Base + 48'h400, 8'd3, BURST_INCR, 6'd0, RESP_OKAY);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
